// File: rtl/aes_mixcol_arbiter.sv
// Two-port arbiter in front of one shared AES (Inv)MixColumns column unit.
// A granted request is transformed one 32-bit column per cycle and then held until the consumer takes it.
module aes_mixcol_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic         a_inv,
    input  logic [127:0] a_state,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic         b_inv,
    input  logic [127:0] b_state,
    output logic         b_ready,
    output logic         out_valid,
    output logic         out_id,
    output logic [127:0] out_state,
    input  logic         out_ready
);

    // state | meaning
    // IDLE  | arbitrate, accept one request
    // BUSY  | transform column col_q per cycle, 0..3
    // DONE  | result held on out_* until out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q;
    logic [127:0]  res_q;
    logic          inv_q;
    logic          id_q;
    logic          last_q;
    logic          grant_b;
    logic          hs;
    logic [31:0]   col_in;
    logic [31:0]   col_out;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] b [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m3 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            b[i]  = c[31-8*i -: 8];
            x2[i] = xt(b[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m3[i] = x2[i] ^ b[i];
            m9[i] = x8[i] ^ b[i];
            mb[i] = x8[i] ^ x2[i] ^ b[i];
            md[i] = x8[i] ^ x4[i] ^ b[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv) begin
            r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end else begin
            r = {x2[0] ^ m3[1] ^ b[2]  ^ b[3],
                 b[0]  ^ x2[1] ^ m3[2] ^ b[3],
                 b[0]  ^ b[1]  ^ x2[2] ^ m3[3],
                 m3[0] ^ b[1]  ^ b[2]  ^ x2[3]};
        end
        return r;
    endfunction

    // last_q = 1 means B won last; both-valid contention goes to the other port
    always_comb begin
        grant_b = b_valid;
        if (a_valid && b_valid) begin
            grant_b = (RR_EN != 0) ? ~last_q : 1'b0;
        end
    end

    // rst_n gating keeps ready low while reset is held
    assign a_ready = rst_n && (state_q == IDLE) && a_valid && !grant_b;
    assign b_ready = rst_n && (state_q == IDLE) && b_valid && grant_b;
    assign hs      = a_ready | b_ready;

    always_comb begin
        col_in = res_q[127:96];
        case (col_q)
            2'd0: col_in = res_q[127:96];
            2'd1: col_in = res_q[95:64];
            2'd2: col_in = res_q[63:32];
            2'd3: col_in = res_q[31:0];
            default: col_in = res_q[127:96];
        endcase
    end

    assign col_out = mix_col(col_in, inv_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs) state_d = BUSY;
            BUSY: if (col_q == 2'd3) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (hs) begin
                res_q  <= b_ready ? b_state : a_state;
                inv_q  <= b_ready ? b_inv : a_inv;
                id_q   <= b_ready;
                last_q <= b_ready;
                col_q  <= 2'd0;
            end else if (state_q == BUSY) begin
                case (col_q)
                    2'd0: res_q[127:96] <= col_out;
                    2'd1: res_q[95:64]  <= col_out;
                    2'd2: res_q[63:32]  <= col_out;
                    2'd3: res_q[31:0]   <= col_out;
                    default: res_q[127:96] <= col_out;
                endcase
                col_q <= col_q + 2'd1;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_id    = id_q;
    assign out_state = res_q;

endmodule

// File: tb/tb_aes_mixcol_arbiter.sv
// Directed plus randomized bench for aes_mixcol_arbiter; a round-robin and a fixed-priority
// instance share all inputs and are compared against a matrix-based GF(2^8) reference.
module tb_aes_mixcol_arbiter;

    logic         clk;
    logic         rst_n;
    logic         a_valid, a_inv, b_valid, b_inv, out_ready;
    logic [127:0] a_state, b_state;
    logic         a_ready, b_ready, out_valid, out_id;
    logic [127:0] out_state;
    logic         fp_a_ready, fp_b_ready, fp_out_valid, fp_out_id;
    logic [127:0] fp_out_state;

    int n_vec = 0;
    int n_err = 0;

    aes_mixcol_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_inv(a_inv), .a_state(a_state), .a_ready(a_ready),
        .b_valid(b_valid), .b_inv(b_inv), .b_state(b_state), .b_ready(b_ready),
        .out_valid(out_valid), .out_id(out_id), .out_state(out_state), .out_ready(out_ready)
    );

    aes_mixcol_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_inv(a_inv), .a_state(a_state), .a_ready(fp_a_ready),
        .b_valid(b_valid), .b_inv(b_inv), .b_state(b_state), .b_ready(fp_b_ready),
        .out_valid(fp_out_valid), .out_id(fp_out_id), .out_state(fp_out_state), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Circulant matrix: coefficient(row r, byte j) = base[(j - r) mod 4]
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check("rst_ready", {a_ready, b_ready}, 2'b00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, 128'h0);
        check("rst_out_id", out_id, 1'b0);
        tick();
        tick();
        check("rst_hold_ready", {a_ready, b_ready, fp_a_ready, fp_b_ready}, 4'b0000);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    // One request from port id; fixed 4-edge latency, then hold cycles of backpressure
    task automatic do_txn(input logic id, input logic inv, input logic [127:0] st,
                          input logic [127:0] exp, input int hold);
        logic [127:0] held;
        a_valid   = !id;
        b_valid   = id;
        a_inv     = inv;
        b_inv     = inv;
        a_state   = id ? rnd128() : st;
        b_state   = id ? st : rnd128();
        out_ready = 1'b0;
        #1;
        check("grant_ready", {a_ready, b_ready}, id ? 2'b01 : 2'b10);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_state = rnd128();
        b_state = rnd128();
        a_inv   = ~inv;
        b_inv   = ~inv;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("busy_no_valid", out_valid, 1'b0);
        end
        tick();
        check("done_valid", out_valid, 1'b1);
        check("done_state", out_state, exp);
        check("done_id", out_id, id);
        held    = out_state;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_state", out_state, held);
            check("hold_ready", {a_ready, b_ready}, 2'b00);
        end
        out_ready = 1'b1;
        tick();
        check("release_idle", out_valid, 1'b0);
        check("no_same_edge_accept", a_ready | b_ready, 1'b1);
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] st, fw, sa, sb;
        logic         exp_b;
        a_valid = 0; b_valid = 0; a_inv = 0; b_inv = 0; out_ready = 0;
        a_state = '0; b_state = '0;

        apply_reset();

        // First handshake right after reset release
        do_txn(1'b0, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
        do_txn(1'b1, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
               128'hdb135345_f20a225c_01010101_c6c6c6c6, 0);
        do_txn(1'b0, 1'b0, {128{1'b1}}, {128{1'b1}}, 0);
        do_txn(1'b1, 1'b0, 128'h0, 128'h0, 0);
        do_txn(1'b0, 1'b1, 128'h0, 128'h0, 0);

        // Backpressure
        st = rnd128();
        do_txn(1'b1, 1'b0, st, model(st, 1'b0), 10);

        // Reset in BUSY while B's column 2 is next
        b_valid = 1'b1;
        b_inv   = 1'b0;
        b_state = rnd128();
        #1;
        check("pre_abort_ready", {a_ready, b_ready}, 2'b01);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_state", out_state, 128'h0);
        check("abort_id", out_id, 1'b0);
        check("abort_ready", {a_ready, b_ready}, 2'b00);
        tick();
        b_valid = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_valid", out_valid, 1'b0);
        end
        st = rnd128();
        do_txn(1'b0, 1'b1, st, model(st, 1'b1), 2);

        // Contention from reset: round-robin alternates, fixed priority always A
        apply_reset();
        sa = rnd128();
        sb = rnd128();
        a_state = sa; b_state = sb; a_inv = 1'b0; b_inv = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_b = (g % 2 == 1);
            check("rr_grant", {a_ready, b_ready}, exp_b ? 2'b01 : 2'b10);
            check("fp_grant", {fp_a_ready, fp_b_ready}, 2'b10);
            tick();
            for (int t = 1; t <= 4; t++) begin
                tick();
                check("rr_gap_ready", {a_ready, b_ready, fp_a_ready, fp_b_ready}, 4'b0000);
                if (t == 4) begin
                    check("rr_out_valid", out_valid, 1'b1);
                    check("rr_out_id", out_id, exp_b);
                    check("rr_out_state", out_state, exp_b ? model(sb, 1'b1) : model(sa, 1'b0));
                    check("fp_out_id", fp_out_id, 1'b0);
                    check("fp_out_state", fp_out_state, model(sa, 1'b0));
                end
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;

        // Random round trips: forward on A, inverse of that on B returns the original
        for (int n = 0; n < 1000; n++) begin
            st = rnd128();
            fw = model(st, 1'b0);
            do_txn(1'b0, 1'b0, st, fw, 0);
            do_txn(1'b1, 1'b1, fw, st, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_mixcol_arbiter.md
AES_MIXCOL_ARBITER -- requirements
Module: aes_mixcol_arbiter

Interface
REQ-001 The block SHALL have one parameter: RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with port A winning.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A has a state to transform.
- a_inv  input  1  A operation select: 0 = MixColumns, 1 = InvMixColumns.
- a_state  input  128  A state; column c = bits [127-32c -: 32]; row 0 = MSB byte of the column.
- a_ready  output  1  A request accepted this cycle.
- b_valid  input  1  as a_valid, requester B.
- b_inv  input  1  as a_inv, requester B.
- b_state  input  128  as a_state, requester B.
- b_ready  output  1  as a_ready, requester B.
- out_valid  output  1  result available.
- out_id  output  1  owner of the result: 0 = A, 1 = B.
- out_state  output  128  transformed state.
- out_ready  input  1  consumer accepts the result.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 In IDLE, the grant SHALL be computed combinationally from a_valid and b_valid. Ready SHALL be asserted only to the granted valid requester, and only in IDLE.
REQ-005 With RR_EN=1 and both requesters valid, the grant SHALL go to the port not granted last. A lone valid requester SHALL always win.
REQ-006 With RR_EN=0 and both requesters valid, A SHALL win.
REQ-007 The last-grant register SHALL update only on an accepted handshake.
REQ-008 On a handshake (valid & ready at a rising edge), the block SHALL:
- capture the state, inv and id into internal registers;
- clear the column counter to 0;
- move to BUSY.
REQ-009 Requester inputs SHALL be ignored outside the handshake edge. Dropping valid without ready has no effect.
REQ-010 BUSY SHALL transform one 32-bit column per cycle, column 0 first, using one shared column unit that is reused across cycles.
REQ-011 The forward (inv=0) column matrix SHALL be rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
REQ-012 The inverse (inv=1) column matrix SHALL be rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
REQ-013 All column arithmetic SHALL be GF(2^8) with reduction polynomial 0x11b: xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0x00).
REQ-014 Each transformed column SHALL be written back into the same column slot of the internal result register.
REQ-015 After column 3 is written, the FSM SHALL enter DONE. If the handshake is at edge k, out_valid SHALL be high after edge k+4.
REQ-016 In DONE, out_valid SHALL be 1 and out_state/out_id SHALL be held stable until out_ready=1 at a rising edge. The FSM SHALL then return to IDLE.
REQ-017 Out of DONE there SHALL be no same-edge new acceptance. Minimum spacing between consecutive handshakes is 6 cycles.
REQ-018 In DONE, out_valid SHALL stay high indefinitely while out_ready is held at 0. No request SHALL be accepted in BUSY or DONE.
REQ-019 out_state SHALL be valid only when out_valid=1; its value at other times is don't-care but deterministic.

Reset
REQ-020 While rst_n=0, the block SHALL hold:
- state = IDLE;
- out_valid = 0, out_id = 0, out_state = 0;
- a_ready = 0, b_ready = 0;
- column counter = 0;
- last-grant = B, so A wins the first contention.
REQ-021 Reset asserted mid-BUSY or mid-DONE SHALL abort immediately and discard the transaction. No out_valid pulse SHALL follow reset release.
REQ-022 The first handshake SHALL be possible at the first rising edge after rst_n rises.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Forward: A sends inv=0, state 0xdb135345_f20a225c_01010101_c6c6c6c6 -> out_state 0x8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_id=0, out_valid 4 edges after the handshake.
- Inverse: B sends inv=1 with the forward result above -> out_state 0xdb135345_f20a225c_01010101_c6c6c6c6, out_id=1.
- Contention, RR_EN=1: A and B held valid continuously from reset -> grants A, B, A, B; handshakes spaced exactly 6 cycles with out_ready=1. RR_EN=0 -> A every time.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state constant, a_ready=b_ready=0 throughout; single release cycle -> IDLE.
- Reset mid-BUSY: rst_n low at column 2 -> outputs 0 immediately; after release, no stale out_valid and a new request completes correctly.
- Boundary data: 0xffffffff per column forward -> 0xffffffff; all-zero state -> all zero; inverse of forward for 1000 random states equals the original.
